// File: rtl/aes_key_sync_loader.sv
// aes_key_sync_loader: assembles a 128-bit key and a 128-bit sync from one
// Avalon-ST config packet. It then hands the pair to the AES encryptor over
// a valid/rdy handshake, delivering exactly one pair per good packet.
//
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   cfg_data/valid/  config stream: key words then sync words, MS word first
//   sop/eop, cfg_rdy
//   key_out,sync_out assembled pair, stable while key_valid=1
//   key_valid/rdy    key+sync handshake to the encryptor
//   err_short        one-cycle pulse: packet ended early
//   err_long         one-cycle pulse: packet ran past its last word
//   reissue          (AES_SYNC_AUTO_INC_EN only) re-present the last pair
//                    with sync incremented by one
//
// Optional feature macro: AES_SYNC_AUTO_INC_EN
module aes_key_sync_loader #(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  input  logic                  cfg_sop,
  input  logic                  cfg_eop,
  output logic                  cfg_rdy,
  output logic [127:0]          key_out,
  output logic [127:0]          sync_out,
  output logic                  key_valid,
  input  logic                  key_rdy,
`ifdef AES_SYNC_AUTO_INC_EN
  input  logic                  reissue,
`endif
  output logic                  err_short,
  output logic                  err_long
);

  localparam int unsigned WORDS_PER_FIELD = 128 / WORD_WIDTH;
  localparam int unsigned NUM_WORDS       = 2 * WORDS_PER_FIELD;
  localparam int unsigned CNT_W           = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PRESENT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [255:0]     shadow;
`ifdef AES_SYNC_AUTO_INC_EN
  logic             has_pair;
`endif

  logic             cfg_xfer_c;
  logic [CNT_W-1:0] idx_c;
  logic [7:0]       lsb_c;
  logic [255:0]     shadow_wr_c;
  logic             store_c;

  // A sop word always lands in slot 0, even in the middle of a packet.
  assign cfg_xfer_c = cfg_valid & cfg_rdy;
  assign idx_c      = cfg_sop ? '0 : cnt;
  assign lsb_c      = 8'((NUM_WORDS - 1 - 32'(idx_c)) * WORD_WIDTH);

  // Words are stored only if they start a packet or continue one that a sop
  // opened. While draining, only a new sop is stored.
  assign store_c = cfg_xfer_c &&
                   (state == DRAIN ? cfg_sop : (cfg_sop || cnt != '0));

  // The shadow with the incoming word merged in. The last word feeds the
  // outputs directly, with no extra cycle.
  always_comb begin
    shadow_wr_c = shadow;
    shadow_wr_c[lsb_c +: WORD_WIDTH] = cfg_data;
  end

  // Control FSM and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= COLLECT;
      cnt       <= '0;
      shadow    <= '0;
      cfg_rdy   <= 1'b0;
      key_out   <= '0;
      sync_out  <= '0;
      key_valid <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
`ifdef AES_SYNC_AUTO_INC_EN
      has_pair  <= 1'b0;
`endif
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        COLLECT, DRAIN: begin
          cfg_rdy <= 1'b1;
          if (store_c) begin
            shadow <= shadow_wr_c;
            if (idx_c == LAST_IDX) begin
              cnt <= '0;
              if (cfg_eop) begin
                key_out   <= shadow_wr_c[255:128];
                sync_out  <= shadow_wr_c[127:0];
                key_valid <= 1'b1;
                cfg_rdy   <= 1'b0;
                state     <= PRESENT;
`ifdef AES_SYNC_AUTO_INC_EN
                has_pair  <= 1'b1;
`endif
              end else begin
                err_long <= 1'b1;
                state    <= DRAIN;
              end
            end else if (cfg_eop) begin
              err_short <= 1'b1;
              cnt       <= '0;
              state     <= COLLECT;
            end else begin
              cnt   <= idx_c + CNT_W'(1);
              state <= COLLECT;
            end
          end else if (cfg_xfer_c && state == DRAIN && cfg_eop) begin
            cnt   <= '0;
            state <= COLLECT;
          end
`ifdef AES_SYNC_AUTO_INC_EN
          // Any config transfer this cycle wins over reissue.
          else if (!cfg_xfer_c && state == COLLECT && cnt == '0 &&
                   has_pair && reissue) begin
            sync_out  <= sync_out + 128'(1);
            key_valid <= 1'b1;
            cfg_rdy   <= 1'b0;
            state     <= PRESENT;
          end
`endif
        end
        PRESENT: begin
          if (key_rdy) begin
            key_valid <= 1'b0;
            cfg_rdy   <= 1'b1;
            state     <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: doc/aes_key_sync_loader.md
Name: aes_key_sync_loader

Overview:
Upstream feeder of the AES encryptor's key/sync port. It receives key and sync material as a short Avalon-ST configuration packet and assembles the 128-bit key and 128-bit sync. It then presents both on a valid/rdy key+sync handshake (dvr_key_if master side). The encryptor consumes one key+sync pair per message, and this block supplies exactly one pair per accepted config packet.

Parameters:
WORD_WIDTH, 32, config stream data width in bits; must divide 128 (legal 8/16/32/64/128).
WORDS_PER_FIELD, 128/WORD_WIDTH, derived; words per key and per sync; not to be overridden.

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-low
cfg_data  input  WORD_WIDTH  config word (key words then sync words, MS word first)
cfg_valid  input  1  config word valid
cfg_sop  input  1  first word of config packet
cfg_eop  input  1  last word of config packet
cfg_rdy  output  1  block accepts config word
key_out  output  128  assembled key
sync_out  output  128  assembled sync
key_valid  output  1  key_out/sync_out valid
key_rdy  input  1  encryptor accepts key+sync
err_short  output  1  one-cycle pulse: packet ended before 2*WORDS_PER_FIELD words
err_long  output  1  one-cycle pulse: packet exceeded 2*WORDS_PER_FIELD words

Behaviour:
- Reset values: cfg_rdy=0, key_valid=0, key_out=0, sync_out=0, err_short=0, err_long=0, word counter=0, state=COLLECT. cfg_rdy goes 1 in the first cycle after reset release.
- Word transfer = cfg_valid & cfg_rdy on a rising clk. Key+sync transfer = key_valid & key_rdy.
- Packet layout: words 0..WORDS_PER_FIELD-1 form the key. Word 0 goes to key_out[127 -: WORD_WIDTH]. Remaining WORDS_PER_FIELD words form sync in the same order. Total N = 2*WORDS_PER_FIELD (8 at default).
- Words are written into a shadow register. key_out/sync_out update only on the COLLECT->PRESENT transition, so outputs are stable while key_valid=1.
- COLLECT: cfg_rdy=1, key_valid=0.
  - Transfer with cfg_sop=1: counter restarts; the word is stored as word 0, including mid-packet.
  - Transfer without sop while counter=0: word dropped, no error.
  - Transfer of word N-1 with eop=1: shadow copied to outputs; state -> PRESENT; counter=0.
  - Transfer with eop=1 at index < N-1: err_short pulses the next cycle; counter=0; stay in COLLECT; outputs unchanged.
  - Transfer of word N-1 with eop=0: err_long pulses the next cycle; state -> DRAIN.
- DRAIN: cfg_rdy=1; words are discarded. A transfer with eop=1 -> COLLECT with counter=0. A transfer with sop=1 restarts the packet as word 0 and enters COLLECT.
- PRESENT: cfg_rdy=0, key_valid=1. On key+sync transfer: key_valid=0 and state -> COLLECT in the next cycle. Latency from last-word accept to key_valid=1 is 1 cycle. Minimum turnaround from handoff to cfg_rdy=1 is 1 cycle.
- key_valid never deasserts without a handoff, except on reset.
- Reset mid-packet or mid-PRESENT: everything returns to reset values immediately (asynchronous); the partial packet is lost.
- Errors never assert key_valid. err_short and err_long are never high in the same cycle.

Optional Feature:
AES_SYNC_AUTO_INC_EN.
- Defined:
  - Extra input port reissue (1 bit) is present.
  - In COLLECT with counter=0 and a previously delivered pair, a reissue pulse re-presents the pair: key_out unchanged, sync_out = sync_out + 1 mod 2^128 (full 128-bit carry).
  - State -> PRESENT in the next cycle.
  - reissue is ignored in any other state or when counter != 0.
  - A cfg transfer in the same cycle as reissue has priority; reissue is dropped.
- Not defined: no reissue port; sync changes only via config packets.

Test Plan:
- Nominal: 8-word packet 00010203/04050607/08090a0b/0c0d0e0f/00112233/44556677/8899aabb/ccddeeff, key_rdy=1 -> key_valid=1 one cycle after the last word; key_out=000102..0f; sync_out=0011..ff; then cfg_rdy=1.
- Backpressure: key_rdy=0 for 20 cycles after load -> key_valid held at 1 with key_out/sync_out constant; cfg_rdy=0 throughout; handoff on the first key_rdy=1 cycle.
- Short packet: 5 words with eop on word 4 -> err_short single pulse; key_valid stays 0; a following valid 8-word packet loads correctly.
- Long packet: 11 words, eop on word 10 -> err_long pulse after word 7; words 8-10 drained; no key_valid; cfg_rdy=1 after word 10.
- sop restart + reset: sop at word 3, then 8 clean words -> output equals the last 8 words. Then rst=0 during the next packet -> all outputs 0 immediately, state COLLECT.
- With AES_SYNC_AUTO_INC_EN: load sync 0000...ffffffff_ffffffff, handoff, pulse reissue -> sync_out = 00000000_00000001_00000000_00000000, key unchanged, key_valid=1 next cycle.
